// File: rtl/decode_stage_piped.sv
// Registered, handshaked instruction decoder for the vector ASIP.
// Scalar/vector/flag scoreboards stall RAW/WAW hazards until writeback retires them.
module decode_stage_piped #(
    parameter int INSTR_W    = 16,
    parameter int REG_W      = 4,
    parameter int IMM_W      = 8,
    parameter int FLAG_CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               MemoryWrite,
    output logic [1:0]         WriteRegFrom,
    output logic [REG_W-1:0]   RegToWrite,
    output logic [IMM_W-1:0]   Immediate,
    output logic               writeMemFrom,
    output logic               RegWriteEnSc,
    output logic               RegWriteEnVec,
    output logic               OverWriteNz,
    output logic [2:0]         PcWriteEn,
    output logic [2:0]         AluOpCode,
    output logic               illegal,
    input  logic               wb_valid,
    input  logic               wb_vec,
    input  logic [REG_W-1:0]   wb_reg,
    input  logic               wb_flag,
    output logic [15:0]        stall_cnt
);

    localparam int NREG = 1 << REG_W;
    localparam logic [FLAG_CNT_W-1:0] FLAG_MAX = '1;

    typedef enum logic [3:0] {
        OP_LOSC  = 4'h0, OP_XOR  = 4'h1, OP_ADD   = 4'h2, OP_SUB   = 4'h3,
        OP_MUL   = 4'h4, OP_RSHF = 4'h5, OP_LSHF  = 4'h6, OP_INC   = 4'h7,
        OP_JE    = 4'h8, OP_JNE  = 4'h9, OP_JMP   = 4'hA, OP_ILLB  = 4'hB,
        OP_SVPIX = 4'hC, OP_LOPIX = 4'hD, OP_ILLE = 4'hE, OP_LMEM  = 4'hF
    } opcode_t;

    opcode_t          op;
    logic [3:0]       opRaw;
    logic [REG_W-1:0] rd, rs1, rs2;

    assign opRaw = in_instr[INSTR_W-1 -: 4];
    assign op    = opcode_t'(opRaw);
    assign rd    = in_instr[INSTR_W-5 -: REG_W];
    assign rs1   = in_instr[INSTR_W-5-REG_W -: REG_W];
    assign rs2   = in_instr[INSTR_W-5-2*REG_W -: REG_W];

    logic             dMemWr, dWmf, dSc, dVec, dNz, dIll;
    logic [1:0]       dWrf;
    logic [2:0]       dPc, dAlu;
    logic             useV1, useV2, useVRd, useSRd, useSRs1, rdFlags;

    always_comb begin
        dMemWr  = 1'b0;
        dWmf    = 1'b0;
        dSc     = 1'b0;
        dVec    = 1'b0;
        dNz     = 1'b0;
        dIll    = 1'b0;
        dWrf    = 2'd0;
        dPc     = 3'b000;
        dAlu    = 3'd0;
        useV1   = 1'b0;
        useV2   = 1'b0;
        useVRd  = 1'b0;
        useSRd  = 1'b0;
        useSRs1 = 1'b0;
        rdFlags = 1'b0;
        unique case (op)
            OP_LOSC: begin
                dSc  = 1'b1;
                dWrf = 2'd2;
            end
            OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF: begin
                dVec  = 1'b1;
                dWrf  = 2'd1;
                dAlu  = opRaw[2:0];
                dNz   = 1'b1;
                useV1 = 1'b1;
                useV2 = 1'b1;
            end
            OP_INC: begin
                dSc    = 1'b1;
                dWrf   = 2'd1;
                dAlu   = 3'd7;
                dNz    = 1'b1;
                useSRd = 1'b1;
            end
            OP_JE: begin
                dPc     = 3'b010;
                rdFlags = 1'b1;
            end
            OP_JNE: begin
                dPc     = 3'b001;
                rdFlags = 1'b1;
            end
            OP_JMP:   dPc = 3'b100;
            OP_SVPIX: begin
                dMemWr  = 1'b1;
                dWmf    = 1'b1;
                useVRd  = 1'b1;
                useSRs1 = 1'b1;
            end
            OP_LOPIX: begin
                dVec    = 1'b1;
                dWmf    = 1'b1;
                useSRs1 = 1'b1;
            end
            OP_LMEM:  dSc = 1'b1;
            OP_ILLB, OP_ILLE: dIll = 1'b1;
        endcase
    end

    logic [NREG-1:0]       scBusy, vecBusy, scPend, vecPend, heldMask;
    logic [FLAG_CNT_W-1:0] flagCnt;
    logic [FLAG_CNT_W:0]   flagEff;
    logic                  rstDone, hazard, accept, depart;

    // The bundle sitting in the output register is treated as already in flight.
    assign heldMask = out_valid ? (NREG'(1) << RegToWrite) : '0;
    assign scPend   = scBusy  | (RegWriteEnSc  ? heldMask : '0);
    assign vecPend  = vecBusy | (RegWriteEnVec ? heldMask : '0);
    assign flagEff  = {1'b0, flagCnt} + (FLAG_CNT_W+1)'(out_valid && OverWriteNz);

    always_comb begin
        hazard = 1'b0;
        if (useV1   && vecPend[rs1]) hazard = 1'b1;
        if (useV2   && vecPend[rs2]) hazard = 1'b1;
        if (useVRd  && vecPend[rd])  hazard = 1'b1;
        if (useSRd  && scPend[rd])   hazard = 1'b1;
        if (useSRs1 && scPend[rs1])  hazard = 1'b1;
        if (dSc     && scPend[rd])   hazard = 1'b1;
        if (dVec    && vecPend[rd])  hazard = 1'b1;
        if (rdFlags && flagEff != '0) hazard = 1'b1;
        if (dNz     && flagEff >= {1'b0, FLAG_MAX}) hazard = 1'b1;
    end

    assign in_ready = rstDone && !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign depart   = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstDone       <= 1'b0;
            out_valid     <= 1'b0;
            MemoryWrite   <= 1'b0;
            WriteRegFrom  <= '0;
            RegToWrite    <= '0;
            Immediate     <= '0;
            writeMemFrom  <= 1'b0;
            RegWriteEnSc  <= 1'b0;
            RegWriteEnVec <= 1'b0;
            OverWriteNz   <= 1'b0;
            PcWriteEn     <= '0;
            AluOpCode     <= '0;
            illegal       <= 1'b0;
        end else begin
            rstDone <= 1'b1;
            if (accept) begin
                out_valid     <= 1'b1;
                MemoryWrite   <= dMemWr;
                WriteRegFrom  <= dWrf;
                RegToWrite    <= rd;
                Immediate     <= in_instr[IMM_W-1:0];
                writeMemFrom  <= dWmf;
                RegWriteEnSc  <= dSc;
                RegWriteEnVec <= dVec;
                OverWriteNz   <= dNz;
                PcWriteEn     <= dPc;
                AluOpCode     <= dAlu;
                illegal       <= dIll;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Writeback clears first so a departing writer of the same index wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scBusy  <= '0;
            vecBusy <= '0;
        end else begin
            logic [NREG-1:0] scNext, vecNext;
            scNext  = scBusy;
            vecNext = vecBusy;
            if (wb_valid) begin
                if (wb_vec) vecNext[wb_reg] = 1'b0;
                else        scNext[wb_reg]  = 1'b0;
            end
            if (depart && RegWriteEnSc)  scNext  = scNext  | heldMask;
            if (depart && RegWriteEnVec) vecNext = vecNext | heldMask;
            scBusy  <= scNext;
            vecBusy <= vecNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flagCnt <= '0;
        end else if (depart && OverWriteNz) begin
            if (!wb_flag && flagCnt != FLAG_MAX) flagCnt <= flagCnt + 1'b1;
        end else if (wb_flag && flagCnt != '0) begin
            flagCnt <= flagCnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
